// File: rtl/csa_reset_ctrl.sv
// ---------------------------------------------------------------------------
// csa_reset_ctrl
//
// Per-channel sequencer for a charge-sensitive amplifier (CSA) front end.
// A qualified discriminator hit starts a sequence:
//   IDLE -> HOLD (hold_delay cycles) -> SAMPLE (ADC handshake) -> RESET -> IDLE
// During RESET the CSA is held at its DC level by csa_reset. A power-on /
// reset_n sequence also parks the CSA in RESET for POR_RESET_CYCLES cycles.
//
// Optional feature (compile-time macro CSA_PERIODIC_RESET_EN):
//   when defined, a 24-bit idle counter forces a RESET after periodic_cycles
//   consecutive IDLE cycles (periodic_cycles = 0 disables it). When the macro
//   is undefined, periodic_cycles is ignored.
//
// Parameters:
//   POR_RESET_CYCLES  csa_reset cycles issued after reset_n release (1..65535)
//   ADC_TIMEOUT       max SAMPLE cycles waiting for adc_done       (1..65535)
//
// Ports:
//   clk              in   single clock, all state on the rising edge
//   reset_n          in   synchronous active-low reset
//   enable           in   channel enable, gates only the IDLE exit on a hit
//   hit              in   discriminator level, synchronous to clk
//   hold_delay[3:0]  in   cycles from hit detection to sample request
//   reset_length[7:0] in  csa_reset pulse length (0 behaves as 1)
//   periodic_cycles[23:0] in  IDLE cycles before a periodic reset (0 = off)
//   adc_done         in   ADC acknowledge of sample_req
//   sample_req       out  request ADC conversion of the CSA output
//   csa_reset        out  CSA reset drive (high = held at DC level)
//   busy             out  high whenever the sequencer is not in IDLE
//   missed_hits[7:0] out  saturating count of hit rising edges while busy
//   timeout_flag     out  sticky, set when SAMPLE times out
// ---------------------------------------------------------------------------
module csa_reset_ctrl #(
  parameter int POR_RESET_CYCLES = 16,
  parameter int ADC_TIMEOUT      = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        hit,
  input  logic [3:0]  hold_delay,
  input  logic [7:0]  reset_length,
  input  logic [23:0] periodic_cycles,
  input  logic        adc_done,
  output logic        sample_req,
  output logic        csa_reset,
  output logic        busy,
  output logic [7:0]  missed_hits,
  output logic        timeout_flag
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_HOLD   = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_RESET  = 2'd3;

  localparam logic [15:0] POR_LOAD     = 16'(POR_RESET_CYCLES);
  localparam logic [15:0] TIMEOUT_LOAD = 16'(ADC_TIMEOUT);

  logic [1:0]  state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [7:0]  missed_n;
  logic        timeout_n;
  logic        hit_prev;
  logic        hit_rise;
  logic [15:0] rst_len;

  // Hits are edge-qualified so a level held across a sequence is not
  // mistaken for a new event when the sequencer returns to IDLE.
  assign hit_rise = hit & ~hit_prev;

  // A zero-length reset request still produces a single-cycle pulse.
  assign rst_len = (reset_length == 8'd0) ? 16'd1 : {8'd0, reset_length};

`ifdef CSA_PERIODIC_RESET_EN
  logic [23:0] pcnt, pcnt_n;
  logic [24:0] pcnt_inc;

  // Compare one bit wider so a periodic_cycles value lowered below the
  // running count fires immediately instead of waiting for a wrap.
  assign pcnt_inc = {1'b0, pcnt} + 25'd1;
`else
  logic unused_periodic;
  assign unused_periodic = ^periodic_cycles;
`endif

  // Single counter is reused: hold countdown, ADC timeout, reset length.
  // Each phase ends on the edge where the counter reads 1, so a load of N
  // keeps the phase visible for exactly N cycles.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    timeout_n = timeout_flag;
    missed_n  = missed_hits;
`ifdef CSA_PERIODIC_RESET_EN
    pcnt_n    = pcnt;
`endif

    case (state)
      ST_IDLE: begin
        if (enable && hit_rise) begin
          if (hold_delay == 4'd0) begin
            state_n = ST_SAMPLE;
            cnt_n   = TIMEOUT_LOAD;
          end else begin
            state_n = ST_HOLD;
            cnt_n   = {12'd0, hold_delay};
          end
`ifdef CSA_PERIODIC_RESET_EN
          pcnt_n = 24'd0;
        end else if ((periodic_cycles != 24'd0) &&
                     (pcnt_inc >= {1'b0, periodic_cycles})) begin
          state_n = ST_RESET;
          cnt_n   = rst_len;
          pcnt_n  = 24'd0;
        end else begin
          pcnt_n = pcnt_inc[23:0];
`endif
        end
      end

      ST_HOLD: begin
        if (cnt <= 16'd1) begin
          state_n = ST_SAMPLE;
          cnt_n   = TIMEOUT_LOAD;
        end else begin
          cnt_n = cnt - 16'd1;
        end
      end

      ST_SAMPLE: begin
        if (adc_done) begin
          state_n = ST_RESET;
          cnt_n   = rst_len;
        end else if (cnt <= 16'd1) begin
          state_n   = ST_RESET;
          cnt_n     = rst_len;
          timeout_n = 1'b1;
        end else begin
          cnt_n = cnt - 16'd1;
        end
      end

      default: begin
        if (cnt <= 16'd1) begin
          state_n = ST_IDLE;
          cnt_n   = 16'd0;
        end else begin
          cnt_n = cnt - 16'd1;
        end
      end
    endcase

    if ((state != ST_IDLE) && hit_rise && (missed_hits != 8'hFF)) begin
      missed_n = missed_hits + 8'd1;
    end
  end

  // Outputs are registered from the next state so they change on the same
  // edge as the state itself.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= ST_RESET;
      cnt          <= POR_LOAD;
      hit_prev     <= 1'b0;
      sample_req   <= 1'b0;
      csa_reset    <= 1'b1;
      busy         <= 1'b1;
      missed_hits  <= 8'd0;
      timeout_flag <= 1'b0;
`ifdef CSA_PERIODIC_RESET_EN
      pcnt         <= 24'd0;
`endif
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      hit_prev     <= hit;
      sample_req   <= (state_n == ST_SAMPLE);
      csa_reset    <= (state_n == ST_RESET);
      busy         <= (state_n != ST_IDLE);
      missed_hits  <= missed_n;
      timeout_flag <= timeout_n;
`ifdef CSA_PERIODIC_RESET_EN
      pcnt         <= pcnt_n;
`endif
    end
  end

endmodule

// File: doc/csa_reset_ctrl.md
CSA_RESET_CTRL -- requirements
Module: csa_reset_ctrl

Interface
REQ-001 Parameter POR_RESET_CYCLES, 16: csa_reset cycles issued after reset_n release.
REQ-002 Parameter ADC_TIMEOUT, 255: max cycles waiting for adc_done in SAMPLE.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 reset_n  input  1  synchronous, active-low reset.
REQ-005 enable  input  1  channel enable; 0 blocks new hit-triggered sequences.
REQ-006 hit  input  1  discriminator output, synchronous to clk, level.
REQ-007 hold_delay  input  4  cycles between hit detection and sample request.
REQ-008 reset_length  input  8  csa_reset pulse length in cycles (0 treated as 1).
REQ-009 periodic_cycles  input  24  IDLE cycles before periodic reset (0 disables).
REQ-010 adc_done  input  1  ADC acknowledge of sample_req.
REQ-011 sample_req  output  1  request ADC conversion of CSA output.
REQ-012 csa_reset  output  1  drives CSA reset; high holds CSA output at its DC level.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 missed_hits  output  8  saturating count of hits ignored while busy.
REQ-015 timeout_flag  output  1  sticky; set on ADC timeout.

Function
REQ-016 FSM states: IDLE, HOLD, SAMPLE, RESET; all outputs registered.
REQ-017 IDLE: enable=1 and hit=1 at edge N -> HOLD at N+1 with counter=hold_delay; if hold_delay=0 -> SAMPLE at N+1.
REQ-018 HOLD: counter decrements each cycle; transition to SAMPLE on the edge where counter equals 1.
REQ-019 SAMPLE: sample_req=1 for every cycle in SAMPLE; adc_done=1 -> RESET next edge, sample_req drops the same edge.
REQ-020 SAMPLE timeout: ADC_TIMEOUT cycles without adc_done -> RESET, timeout_flag set to 1 until reset_n.
REQ-021 RESET: csa_reset=1 for exactly max(reset_length,1) cycles, then IDLE with csa_reset=0; reset_length sampled on RESET entry only.
REQ-022 hit=1 sampled in HOLD, SAMPLE or RESET -> missed_hits increments once per rising edge of hit, saturating at 255.
REQ-023 Hit is edge-qualified: a hit held high across the return to IDLE does not start a new sequence until it falls and rises again.
REQ-024 enable=0 mid-sequence: current sequence completes normally; only IDLE exit is gated.
REQ-025 adc_done outside SAMPLE is ignored.
REQ-026 busy=0 iff state is IDLE.

Reset
REQ-027 reset_n=0 at an edge: state=RESET, counter=POR_RESET_CYCLES, csa_reset=1, sample_req=0, busy=1, missed_hits=0, timeout_flag=0, periodic counter=0.
REQ-028 After release, csa_reset stays 1 for POR_RESET_CYCLES cycles, then IDLE.
REQ-029 reset_n=0 mid-sequence aborts the sequence immediately at that edge; no partial sample_req.

Configuration
REQ-030 Macro CSA_PERIODIC_RESET_EN: defined -> 24-bit counter increments each IDLE cycle, clears on IDLE exit; reaching periodic_cycles (nonzero) -> RESET with reset_length.
REQ-031 Periodic expiry and qualified hit in the same cycle: hit wins, periodic counter clears.
REQ-032 Macro undefined: no periodic counter; periodic_cycles ignored; RESET entered only via hit sequence or reset_n.

Verification
REQ-033 reset_n low 3 cycles, release -> csa_reset=1 for 16 cycles, busy falls the next cycle, all counters 0.
REQ-034 hold_delay=3, reset_length=5, hit pulse, adc_done 4 cycles after sample_req rises -> sample_req 4 cycles, then csa_reset exactly 5 cycles, then IDLE.
REQ-035 hold_delay=0, adc_done never -> sample_req high 255 cycles, timeout_flag=1, csa_reset pulse follows.
REQ-036 3 hit pulses during SAMPLE, then 300 more during busy -> missed_hits=255, no extra sequences.
REQ-037 Macro defined, periodic_cycles=100, no hits -> csa_reset pulse every 100+reset_length cycles; hit on cycle 100 -> HOLD taken, no periodic reset.
REQ-038 enable=0 with hit pulses -> no sample_req; enable dropped in HOLD -> sequence completes.
